// File: rtl/i2c_slave_reg_ctrl_pkg.sv
// Shared definitions for the I2C register-bank controller: controller state
// encoding and the default register reset value.
package i2c_slave_reg_pkg;

    // Controller states, in the order a typical transaction visits them.
    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        SEL   = 3'd1,
        WRITE = 3'd2,
        FETCH = 3'd3,
        READ  = 3'd4
    } state_t;

    // Reset value of every register unless the instance overrides it.
    localparam logic [7:0] RST_VAL_DEFAULT = 8'h00;

endpackage

// File: rtl/i2c_slave_reg_ctrl_bank.sv
// i2c_reg_bank: DEPTH x 8-bit register file with two write ports and two
// asynchronous read ports. The I2C port has priority; a host write to the
// same address in the same cycle is discarded.
module i2c_reg_bank import i2c_slave_reg_pkg::*; #(
    parameter int         DEPTH   = 16,
    parameter logic [7:0] RST_VAL = RST_VAL_DEFAULT,
    localparam int        ADDR_W  = $clog2(DEPTH)
) (
    input  logic              i_clk,
    input  logic              i_rst_n,
    input  logic              i_i2c_we,
    input  logic [ADDR_W-1:0] i_i2c_addr,
    input  logic [7:0]        i_i2c_wdata,
    input  logic              i_host_we,
    input  logic [ADDR_W-1:0] i_host_addr,
    input  logic [7:0]        i_host_wdata,
    input  logic [ADDR_W-1:0] i_raddr_a,
    output logic [7:0]        o_rdata_a,
    input  logic [ADDR_W-1:0] i_raddr_b,
    output logic [7:0]        o_rdata_b
);

    logic [7:0] r_regs [DEPTH];

    // Register storage: I2C write checked first so it shadows a same-address host write.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_regs[i] <= RST_VAL;
            end
        end else begin
            for (int i = 0; i < DEPTH; i++) begin
                if (i_i2c_we && (i_i2c_addr == ADDR_W'(i))) begin
                    r_regs[i] <= i_i2c_wdata;
                end else if (i_host_we && (i_host_addr == ADDR_W'(i))) begin
                    r_regs[i] <= i_host_wdata;
                end
            end
        end
    end

    assign o_rdata_a = r_regs[i_raddr_a];
    assign o_rdata_b = r_regs[i_raddr_b];

endmodule

// File: rtl/i2c_slave_reg_ctrl.sv
// i2c_slave_reg_ctrl: EEPROM-style register bank controller behind i2c_slave.
// The first byte written in a transaction loads the pointer, further writes
// store and auto-increment, reads stream regs[ptr] with auto-increment.
// A host port gives independent access to the same registers.
// Optional feature macro: I2C_REG_IRQ_EN (adds xfer_done_irq generation).
module i2c_slave_reg_ctrl import i2c_slave_reg_pkg::*; #(
    parameter int         DEPTH   = 16,
    parameter logic [7:0] RST_VAL = RST_VAL_DEFAULT,
    localparam int        ADDR_W  = $clog2(DEPTH)
) (
    input  logic              i_clk,
    input  logic              i_rst_n,
    input  logic              i_slave_selected,
    input  logic              i_write_received,
    input  logic [7:0]        i_data_from_master,
    input  logic              i_data_read_ack,
    output logic [7:0]        o_data_to_master,
    output logic              o_data_valid,
    input  logic              i_host_we,
    input  logic [ADDR_W-1:0] i_host_addr,
    input  logic [7:0]        i_host_wdata,
    output logic [7:0]        o_host_rdata,
    output logic              o_host_collision,
    output logic [ADDR_W-1:0] o_ptr_dbg,
    output logic              o_xfer_done_irq
);

    state_t            r_state;
    state_t            w_next_state;
    logic [ADDR_W-1:0] r_ptr;
    logic [ADDR_W-1:0] w_next_ptr;
    logic              w_i2c_we;
    logic              w_collision;
    logic              w_host_we_eff;
    logic [7:0]        w_rdata_ptr;
    logic [7:0]        w_rdata_host;
    logic [7:0]        w_next_data;
    logic [7:0]        r_data_to_master;
    logic [7:0]        r_host_rdata;
    logic              r_host_collision;

    i2c_reg_bank #(
        .DEPTH   (DEPTH),
        .RST_VAL (RST_VAL)
    ) u_bank (
        .i_clk        (i_clk),
        .i_rst_n      (i_rst_n),
        .i_i2c_we     (w_i2c_we),
        .i_i2c_addr   (r_ptr),
        .i_i2c_wdata  (i_data_from_master),
        .i_host_we    (i_host_we),
        .i_host_addr  (i_host_addr),
        .i_host_wdata (i_host_wdata),
        .i_raddr_a    (w_next_ptr),
        .o_rdata_a    (w_rdata_ptr),
        .i_raddr_b    (i_host_addr),
        .o_rdata_b    (w_rdata_host)
    );

    // Next-state and pointer logic; deselect overrides everything, write beats ack.
    always_comb begin
        w_next_state = r_state;
        w_next_ptr   = r_ptr;
        w_i2c_we     = 1'b0;
        if (!i_slave_selected) begin
            w_next_state = IDLE;
        end else begin
            case (r_state)
                IDLE: begin
                    w_next_state = SEL;
                end
                SEL, READ: begin
                    if (i_write_received) begin
                        w_next_ptr   = i_data_from_master[ADDR_W-1:0];
                        w_next_state = WRITE;
                    end else if (i_data_read_ack) begin
                        w_next_ptr   = r_ptr + ADDR_W'(1);
                        w_next_state = FETCH;
                    end
                end
                WRITE: begin
                    if (i_write_received) begin
                        w_i2c_we   = 1'b1;
                        w_next_ptr = r_ptr + ADDR_W'(1);
                    end else if (i_data_read_ack) begin
                        w_next_ptr   = r_ptr + ADDR_W'(1);
                        w_next_state = FETCH;
                    end
                end
                FETCH: begin
                    w_next_state = READ;
                end
                default: begin
                    w_next_state = IDLE;
                end
            endcase
        end
    end

    // Host collision detection and write-first forwarding into the outgoing byte.
    always_comb begin
        w_collision   = i_host_we && w_i2c_we && (i_host_addr == r_ptr);
        w_host_we_eff = i_host_we && !w_collision;
        w_next_data   = w_rdata_ptr;
        if (w_i2c_we && (r_ptr == w_next_ptr)) begin
            w_next_data = i_data_from_master;
        end else if (w_host_we_eff && (i_host_addr == w_next_ptr)) begin
            w_next_data = i_host_wdata;
        end
    end

    // State and pointer registers.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state <= IDLE;
            r_ptr   <= '0;
        end else begin
            r_state <= w_next_state;
            r_ptr   <= w_next_ptr;
        end
    end

    // Registered outputs toward i2c_slave and the host.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_data_to_master <= RST_VAL;
            r_host_rdata     <= RST_VAL;
            r_host_collision <= 1'b0;
        end else begin
            r_data_to_master <= w_next_data;
            r_host_rdata     <= w_rdata_host;
            r_host_collision <= w_collision;
        end
    end

    assign o_data_to_master = r_data_to_master;
    assign o_host_rdata     = r_host_rdata;
    assign o_host_collision = r_host_collision;
    assign o_ptr_dbg        = r_ptr;
    assign o_data_valid     = (r_state == SEL) || (r_state == WRITE) || (r_state == READ);

`ifdef I2C_REG_IRQ_EN
    logic r_sel_q;
    logic r_stored;
    logic r_irq;
    logic w_sel_fall;

    assign w_sel_fall = r_sel_q && !i_slave_selected;

    // Remember whether a data byte landed this transaction; pulse irq on deselect.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_sel_q  <= 1'b0;
            r_stored <= 1'b0;
            r_irq    <= 1'b0;
        end else begin
            r_sel_q <= i_slave_selected;
            r_irq   <= w_sel_fall && r_stored;
            if (w_sel_fall) begin
                r_stored <= 1'b0;
            end else if (w_i2c_we) begin
                r_stored <= 1'b1;
            end
        end
    end

    assign o_xfer_done_irq = r_irq;
`else
    assign o_xfer_done_irq = 1'b0;
`endif

endmodule

// File: tb/tb_i2c_slave_reg_ctrl.sv
// Self-checking bench for i2c_slave_reg_ctrl (DEPTH=16). Keeps its own copy
// of the register file and pointer, queues expected read bytes when a byte is
// requested and compares them once the DUT flags data_valid.
// Honours I2C_REG_IRQ_EN for the expected xfer_done_irq value.
module tb_i2c_slave_reg_ctrl;

    localparam int DEPTH = 16;
`ifdef I2C_REG_IRQ_EN
    localparam logic IRQ_EN = 1'b1;
`else
    localparam logic IRQ_EN = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       rst_n;
    logic       slave_selected;
    logic       write_received;
    logic [7:0] data_from_master;
    logic       data_read_ack;
    logic [7:0] data_to_master;
    logic       data_valid;
    logic       host_we;
    logic [3:0] host_addr;
    logic [7:0] host_wdata;
    logic [7:0] host_rdata;
    logic       host_collision;
    logic [3:0] ptr_dbg;
    logic       xfer_done_irq;

    int         checks   = 0;
    int         failures = 0;
    logic [7:0] mreg [DEPTH];
    logic [3:0] mptr;
    logic       curSel;
    logic [7:0] expQ [$];

    // Free-running 100 MHz clock.
    always #5 clk = ~clk;

    i2c_slave_reg_ctrl #(.DEPTH(DEPTH)) dut (
        .i_clk              (clk),
        .i_rst_n            (rst_n),
        .i_slave_selected   (slave_selected),
        .i_write_received   (write_received),
        .i_data_from_master (data_from_master),
        .i_data_read_ack    (data_read_ack),
        .o_data_to_master   (data_to_master),
        .o_data_valid       (data_valid),
        .i_host_we          (host_we),
        .i_host_addr        (host_addr),
        .i_host_wdata       (host_wdata),
        .o_host_rdata       (host_rdata),
        .o_host_collision   (host_collision),
        .o_ptr_dbg          (ptr_dbg),
        .o_xfer_done_irq    (xfer_done_irq)
    );

    // Single comparison point: counts every check and reports mismatches.
    task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            failures++;
            $display("[TB] FAIL %s: got 0x%0h, want 0x%0h", tag, actual, expected);
        end
    endtask

    // Drives one cycle of inputs; strobes drop again 1 ns after the edge.
    task automatic applyStimulus(input logic sel, input logic wr, input logic [7:0] d, input logic ack,
                                 input logic hwe, input logic [3:0] ha, input logic [7:0] hd);
        curSel           = sel;
        slave_selected   = sel;
        write_received   = wr;
        data_from_master = d;
        data_read_ack    = ack;
        host_we          = hwe;
        host_addr        = ha;
        host_wdata       = hd;
        @(posedge clk);
        #1;
        write_received = 1'b0;
        data_read_ack  = 1'b0;
        host_we        = 1'b0;
    endtask

    task automatic idle();
        applyStimulus(curSel, 1'b0, 8'h00, 1'b0, 1'b0, host_addr, 8'h00);
    endtask

    task automatic selectSlave();
        applyStimulus(1'b1, 1'b0, 8'h00, 1'b0, 1'b0, host_addr, 8'h00);
    endtask

    task automatic deselectSlave();
        applyStimulus(1'b0, 1'b0, 8'h00, 1'b0, 1'b0, host_addr, 8'h00);
    endtask

    // First byte of a write: loads the pointer (upper bits dropped).
    task automatic ptrLoad(input logic [7:0] b);
        applyStimulus(1'b1, 1'b1, b, 1'b0, 1'b0, host_addr, 8'h00);
        mptr = b[3:0];
    endtask

    task automatic dataWrite(input logic [7:0] b);
        applyStimulus(1'b1, 1'b1, b, 1'b0, 1'b0, host_addr, 8'h00);
        mreg[mptr] = b;
        mptr++;
    endtask

    // Master ACKs the byte just sent; the next byte becomes expected.
    task automatic ackByte();
        applyStimulus(1'b1, 1'b0, 8'h00, 1'b1, 1'b0, host_addr, 8'h00);
        mptr++;
        expQ.push_back(mreg[mptr]);
    endtask

    // Waits (bounded) for data_valid and compares the presented byte with the queue head.
    task automatic popAndCheck(input string tag);
        logic [7:0] exp;
        for (int k = 0; k < 4 && !data_valid; k++) idle();
        checkOutput({tag, "_valid"}, 32'(data_valid), 32'd1);
        if (expQ.size() == 0) begin
            checkOutput({tag, "_queue"}, 32'(expQ.size()), 32'd1);
        end else begin
            exp = expQ.pop_front();
            checkOutput(tag, 32'(data_to_master), 32'(exp));
        end
    endtask

    task automatic hostRead(input logic [3:0] a, input string tag);
        applyStimulus(curSel, 1'b0, 8'h00, 1'b0, 1'b0, a, 8'h00);
        checkOutput(tag, 32'(host_rdata), 32'(mreg[a]));
    endtask

    // Main sequence: reset, write/read streaming, wrap, host port, corner events.
    initial begin
        rst_n            = 1'b1;
        slave_selected   = 1'b0;
        write_received   = 1'b0;
        data_from_master = 8'h00;
        data_read_ack    = 1'b0;
        host_we          = 1'b0;
        host_addr        = 4'h0;
        host_wdata       = 8'h00;
        curSel           = 1'b0;
        for (int i = 0; i < DEPTH; i++) mreg[i] = 8'h00;
        mptr = 4'h0;

        #1 rst_n = 1'b0;
        #1;
        checkOutput("rst_dtm", 32'(data_to_master), 32'h00);
        checkOutput("rst_valid", 32'(data_valid), 32'd0);
        checkOutput("rst_hrdata", 32'(host_rdata), 32'h00);
        checkOutput("rst_coll", 32'(host_collision), 32'd0);
        checkOutput("rst_ptr", 32'(ptr_dbg), 32'd0);
        checkOutput("rst_irq", 32'(xfer_done_irq), 32'd0);
        #10 rst_n = 1'b1;

        $display("[TB] write 05,AA,BB");
        selectSlave();
        ptrLoad(8'h05);
        dataWrite(8'hAA);
        dataWrite(8'hBB);
        deselectSlave();
        checkOutput("wr_ptr", 32'(ptr_dbg), 32'(mptr));
        hostRead(4'd5, "wr_reg5");
        hostRead(4'd6, "wr_reg6");

        $display("[TB] repeated-start read");
        selectSlave();
        ptrLoad(8'h05);
        expQ.push_back(mreg[mptr]);
        popAndCheck("rd_first");
        for (int n = 0; n < 2; n++) begin
            ackByte();
            checkOutput("rd_fetch_low", 32'(data_valid), 32'd0);
            idle();
            checkOutput("rd_fetch_1cyc", 32'(data_valid), 32'd1);
            popAndCheck("rd_next");
        end
        deselectSlave();
        checkOutput("rd_ptr", 32'(ptr_dbg), 32'(mptr));

        $display("[TB] pointer mask and wrap");
        selectSlave();
        ptrLoad(8'h1F);
        dataWrite(8'h11);
        dataWrite(8'h22);
        deselectSlave();
        checkOutput("wrap_ptr", 32'(ptr_dbg), 32'd1);
        hostRead(4'd15, "wrap_reg15");
        hostRead(4'd0, "wrap_reg0");

        $display("[TB] host vs I2C writes");
        selectSlave();
        ptrLoad(8'h03);
        applyStimulus(1'b1, 1'b1, 8'h44, 1'b0, 1'b1, 4'd3, 8'h33);
        mreg[3] = 8'h44;
        mptr++;
        checkOutput("coll_pulse", 32'(host_collision), 32'd1);
        idle();
        checkOutput("coll_clear", 32'(host_collision), 32'd0);
        applyStimulus(1'b1, 1'b1, 8'h55, 1'b0, 1'b1, 4'd9, 8'h66);
        mreg[4] = 8'h55;
        mreg[9] = 8'h66;
        mptr++;
        checkOutput("nocoll", 32'(host_collision), 32'd0);
        deselectSlave();
        hostRead(4'd3, "coll_reg3");
        hostRead(4'd4, "both_reg4");
        hostRead(4'd9, "both_reg9");

        $display("[TB] host write forwarded to outgoing byte");
        selectSlave();
        applyStimulus(1'b1, 1'b0, 8'h00, 1'b0, 1'b1, mptr, 8'h5A);
        mreg[mptr] = 8'h5A;
        expQ.push_back(mreg[mptr]);
        popAndCheck("fwd");

        $display("[TB] deselect during fetch, read-first resume");
        ackByte();
        checkOutput("dsel_fetch", 32'(data_valid), 32'd0);
        deselectSlave();
        checkOutput("dsel_valid", 32'(data_valid), 32'd0);
        checkOutput("dsel_ptr", 32'(ptr_dbg), 32'(mptr));
        selectSlave();
        popAndCheck("read_first");

        $display("[TB] pulse while idle ignored");
        deselectSlave();
        applyStimulus(1'b1, 1'b1, 8'h02, 1'b0, 1'b0, host_addr, 8'h00);
        checkOutput("idle_ptr", 32'(ptr_dbg), 32'(mptr));
        checkOutput("idle_to_sel", 32'(data_valid), 32'd1);

        $display("[TB] write and ack together");
        ptrLoad(8'h0A);
        applyStimulus(1'b1, 1'b1, 8'h9C, 1'b1, 1'b0, host_addr, 8'h00);
        mreg[mptr] = 8'h9C;
        mptr++;
        checkOutput("wa_ptr", 32'(ptr_dbg), 32'(mptr));
        expQ.push_back(mreg[mptr]);
        popAndCheck("wa_valid_data");
        deselectSlave();
        hostRead(4'd10, "wa_reg10");

        $display("[TB] transfer-done interrupt");
        selectSlave();
        ptrLoad(8'h02);
        deselectSlave();
        checkOutput("irq_ptr_only", 32'(xfer_done_irq), 32'd0);
        idle();
        checkOutput("irq_ptr_only2", 32'(xfer_done_irq), 32'd0);
        selectSlave();
        ptrLoad(8'h02);
        dataWrite(8'h21);
        deselectSlave();
        checkOutput("irq_pulse", 32'(xfer_done_irq), 32'(IRQ_EN));
        idle();
        checkOutput("irq_clear", 32'(xfer_done_irq), 32'd0);

        $display("[TB] reset during write");
        selectSlave();
        ptrLoad(8'h04);
        dataWrite(8'h3C);
        rst_n = 1'b0;
        #2;
        checkOutput("mrst_ptr", 32'(ptr_dbg), 32'd0);
        checkOutput("mrst_valid", 32'(data_valid), 32'd0);
        checkOutput("mrst_dtm", 32'(data_to_master), 32'h00);
        checkOutput("mrst_hrdata", 32'(host_rdata), 32'h00);
        slave_selected = 1'b0;
        curSel         = 1'b0;
        #2 rst_n = 1'b1;
        for (int i = 0; i < DEPTH; i++) mreg[i] = 8'h00;
        mptr = 4'h0;
        for (int i = 0; i < DEPTH; i++) hostRead(4'(i), "mrst_reg");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
